// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals of mem_arbiter.
// master: requesters plus memory model; slave: the arbiter itself.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported memory with access timeout.
// Define MEM_ARBITER_RR_EN for round-robin on simultaneous requests; otherwise data wins.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no access; arbitrate and latch winner
  // BUSY  | memory access in progress, waiting for mem_ready or timeout
  // DONE  | one-cycle ack (and err if timed out) to the owner
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_d;
  logic        we_lat;
  logic [31:0] addr_lat;
  logic [31:0] wdata_lat;
  logic [31:0] irdata;
  logic [31:0] drdata;
  logic [8:0]  wait_cnt;
  logic        err_armed;
  logic        grant_i;
  logic        grant_d;
  logic        prefer_d;
  logic        timeout;
  logic        finish;
  logic        en;
  logic        we;
  logic        ack_i;
  logic        ack_d;
  logic        err_p;

`ifdef MEM_ARBITER_RR_EN
  logic last_d;

  assign prefer_d = ~last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b1;
    end else if (state == IDLE && (grant_i || grant_d)) begin
      last_d <= grant_d;
    end
  end
`else
  assign prefer_d = 1'b1;
`endif

  assign grant_d = bus.d_req & (~bus.i_req | prefer_d);
  assign grant_i = bus.i_req & ~grant_d;
  // Abort only once 256 not-ready cycles have already elapsed; a late ready still completes
  assign timeout = (wait_cnt == 9'd256) & ~bus.mem_ready;
  assign finish  = bus.mem_ready | timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    en        = 1'b0;
    we        = 1'b0;
    ack_i     = 1'b0;
    ack_d     = 1'b0;
    err_p     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i || grant_d) state_nxt = BUSY;
      end
      BUSY: begin
        en = 1'b1;
        we = we_lat;
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        ack_i     = ~owner_d;
        ack_d     = owner_d;
        err_p     = err_armed;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_d   <= 1'b0;
      we_lat    <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      irdata    <= '0;
      drdata    <= '0;
      wait_cnt  <= '0;
      err_armed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            owner_d   <= grant_d;
            addr_lat  <= grant_d ? bus.d_addr : bus.i_addr;
            we_lat    <= grant_d & bus.d_we;
            wait_cnt  <= '0;
            err_armed <= 1'b0;
            if (grant_d) wdata_lat <= bus.d_wdata;
          end
        end
        BUSY: begin
          if (finish) begin
            err_armed <= ~bus.mem_ready;
            if (!owner_d) begin
              irdata <= bus.mem_ready ? bus.mem_rdata : 32'hDEAD_BEEF;
            end else if (!we_lat) begin
              drdata <= bus.mem_ready ? bus.mem_rdata : 32'hDEAD_BEEF;
            end
          end else begin
            wait_cnt <= wait_cnt + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en    = en;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr_lat;
  assign bus.mem_wdata = wdata_lat;
  assign bus.i_rdata   = irdata;
  assign bus.d_rdata   = drdata;
  assign bus.i_ack     = ack_i;
  assign bus.d_ack     = ack_d;
  assign bus.err       = err_p;
endmodule
